ttn_pll_lock_det: RTL and testbench

//  Lock detector for the emulated Stratix-III-style PLL model. Sits directly downstream of the M (feedback)

---
 rtl/ttn_pll_lock_det.sv | 170 +++++++++++++++++
 tb/tb_ttn_pll_lock_det.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ttn_pll_lock_det.sv
// PLL lock detector: measures ref and fb clock periods on clk and asserts locked
// once LOCK_COUNT consecutive comparisons agree within TOL clk cycles.
module ttn_pll_lock_det #(
    parameter int CNT_W        = 16,
    parameter int TOL          = 2,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ref_clk_in,
    input  logic             fb_clk_in,
    input  logic             clr_sticky,
    output logic             locked,
    output logic             lock_lost,
    output logic             lock_lost_sticky,
    output logic [CNT_W-1:0] ref_period,
    output logic [CNT_W-1:0] fb_period
);
    typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL_V       = (CNT_W+1)'(TOL);
    localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_COUNT - 1);
    localparam logic [7:0]       UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);

    logic [1:0]       ref_sync_q, ref_sync_d, fb_sync_q, fb_sync_d;
    logic             ref_prev_q, ref_prev_d, fb_prev_q, fb_prev_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d, fb_cnt_q, fb_cnt_d;
    logic             ref_valid_q, ref_valid_d, fb_valid_q, fb_valid_d;
    logic [CNT_W-1:0] ref_period_q, ref_period_d, fb_period_q, fb_period_d;
    state_t           state_q, state_d;
    logic [7:0]       match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d, lock_lost_q, lock_lost_d;
    logic             sticky_q, sticky_d;

    logic             ref_edge, fb_edge, ref_stop, cmp, match;
    logic [CNT_W-1:0] ref_inc, fb_inc;
    logic [CNT_W:0]   diff;

    always_comb begin
        ref_sync_d = {ref_sync_q[0], ref_clk_in};
        fb_sync_d  = {fb_sync_q[0], fb_clk_in};
        ref_prev_d = ref_sync_q[1];
        fb_prev_d  = fb_sync_q[1];
        ref_edge   = ref_sync_q[1] & ~ref_prev_q;
        fb_edge    = fb_sync_q[1] & ~fb_prev_q;

        // Saturating increment doubles as the min(cnt+1, all-ones) capture value
        ref_inc  = (ref_cnt_q == CNT_MAX) ? CNT_MAX : ref_cnt_q + CNT_ONE;
        fb_inc   = (fb_cnt_q == CNT_MAX) ? CNT_MAX : fb_cnt_q + CNT_ONE;
        ref_stop = (ref_cnt_q == CNT_MAX) & ~ref_edge;

        ref_cnt_d    = ref_edge ? '0 : ref_inc;
        fb_cnt_d     = fb_edge ? '0 : fb_inc;
        ref_period_d = (ref_edge & ref_valid_q) ? ref_inc : ref_period_q;
        fb_period_d  = (fb_edge & fb_valid_q) ? fb_inc : fb_period_q;
        ref_valid_d  = ref_edge ? 1'b1 : (ref_stop ? 1'b0 : ref_valid_q);
        fb_valid_d   = fb_edge ? 1'b1 : (ref_stop ? 1'b0 : fb_valid_q);

        // Compare against the post-capture fb value so a coincident fb edge counts
        cmp = ref_edge & ref_valid_q & fb_valid_d;
        if (ref_period_d >= fb_period_d) diff = {1'b0, ref_period_d} - {1'b0, fb_period_d};
        else                             diff = {1'b0, fb_period_d} - {1'b0, ref_period_d};
        match = (ref_period_d != CNT_MAX) && (fb_period_d != CNT_MAX) &&
                (fb_cnt_q != CNT_MAX) && (diff <= TOL_V);

        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        lock_lost_d = 1'b0;
        if (ref_stop) begin
            state_d     = ST_UNLOCKED;
            locked_d    = 1'b0;
            lock_lost_d = (state_q == ST_LOCKED);
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (ref_valid_q & fb_valid_q) begin
                        state_d     = ST_ACQUIRE;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (cmp) begin
                        if (!match) begin
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                            if (match_cnt_q == LOCK_LAST) begin
                                state_d    = ST_LOCKED;
                                locked_d   = 1'b1;
                                miss_cnt_d = '0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (cmp) begin
                        if (match) begin
                            miss_cnt_d = '0;
                        end else if (miss_cnt_q == UNLOCK_LAST) begin
                            state_d     = ST_ACQUIRE;
                            locked_d    = 1'b0;
                            lock_lost_d = 1'b1;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end

        // A clear that overlaps the lock_lost pulse is ignored: set wins
        sticky_d = lock_lost_d | (sticky_q & ~(clr_sticky & ~lock_lost_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_sync_q   <= '0;
            fb_sync_q    <= '0;
            ref_prev_q   <= 1'b0;
            fb_prev_q    <= 1'b0;
            ref_cnt_q    <= '0;
            fb_cnt_q     <= '0;
            ref_valid_q  <= 1'b0;
            fb_valid_q   <= 1'b0;
            ref_period_q <= '0;
            fb_period_q  <= '0;
            state_q      <= ST_UNLOCKED;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            ref_sync_q   <= ref_sync_d;
            fb_sync_q    <= fb_sync_d;
            ref_prev_q   <= ref_prev_d;
            fb_prev_q    <= fb_prev_d;
            ref_cnt_q    <= ref_cnt_d;
            fb_cnt_q     <= fb_cnt_d;
            ref_valid_q  <= ref_valid_d;
            fb_valid_q   <= fb_valid_d;
            ref_period_q <= ref_period_d;
            fb_period_q  <= fb_period_d;
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            sticky_q     <= sticky_d;
        end
    end

    assign locked           = locked_q;
    assign lock_lost        = lock_lost_q;
    assign lock_lost_sticky = sticky_q;
    assign ref_period       = ref_period_q;
    assign fb_period        = fb_period_q;

endmodule

// File: tb/tb_ttn_pll_lock_det.sv
// Directed bench for ttn_pll_lock_det; narrow counters keep the stop/saturation cases short.
module tb_ttn_pll_lock_det;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             reset, ref_clk_in, fb_clk_in, clr_sticky;
    logic             locked, lock_lost, lock_lost_sticky;
    logic [CNT_W-1:0] ref_period, fb_period;

    int total = 0;
    int bad = 0;
    int lost_cnt = 0;
    int ref_per = 20, fb_per = 20, ref_ph = 0, fb_ph = 0;
    bit ref_run = 0, fb_run = 0, ref_on = 0, fb_on = 0;

    ttn_pll_lock_det #(.CNT_W(CNT_W), .TOL(2), .LOCK_COUNT(8), .UNLOCK_COUNT(2)) dut (
        .clk(clk), .reset(reset), .ref_clk_in(ref_clk_in), .fb_clk_in(fb_clk_in),
        .clr_sticky(clr_sticky), .locked(locked), .lock_lost(lock_lost),
        .lock_lost_sticky(lock_lost_sticky), .ref_period(ref_period), .fb_period(fb_period)
    );

    always #5 clk = ~clk;

    // Clock generators: a rising edge on the first negedge after run is set
    initial begin
        ref_clk_in = 1'b0;
        forever begin
            @(negedge clk);
            if (ref_run) begin
                if (!ref_on) begin ref_on = 1; ref_ph = 0; end
                else ref_ph = (ref_ph + 1 >= ref_per) ? 0 : ref_ph + 1;
                ref_clk_in = (ref_ph < ref_per / 2);
            end else begin
                ref_on = 0; ref_clk_in = 1'b0;
            end
        end
    end

    initial begin
        fb_clk_in = 1'b0;
        forever begin
            @(negedge clk);
            if (fb_run) begin
                if (!fb_on) begin fb_on = 1; fb_ph = 0; end
                else fb_ph = (fb_ph + 1 >= fb_per) ? 0 : fb_ph + 1;
                fb_clk_in = (fb_ph < fb_per / 2);
            end else begin
                fb_on = 0; fb_clk_in = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (lock_lost === 1'b1) lost_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        ref_run = 0; fb_run = 0; clr_sticky = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start_clocks(input int per);
        ref_per = per; fb_per = per;
        @(posedge clk); #1 fb_run = 1;
        repeat (5) @(posedge clk);
        #1 ref_run = 1;
    endtask

    task automatic wait_lock(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (locked === 1'b1) begin cyc = i; break; end
        end
    endtask

    task automatic wait_unlock(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (locked !== 1'b1) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset();
        ref_run = 0; fb_run = 0; clr_sticky = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
        total++; if (lock_lost_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b want 0", lock_lost_sticky); end
        total++; if (ref_period !== '0) begin bad++; $display("FAIL reset_ref_period: got %0d want 0", ref_period); end
        total++; if (fb_period !== '0) begin bad++; $display("FAIL reset_fb_period: got %0d want 0", fb_period); end
        reset = 1'b0;
    endtask

    task automatic test_lock_equal();
        int cyc;
        int lost0;
        do_reset();
        lost0 = lost_cnt;
        start_clocks(20);
        wait_lock(400, cyc);
        total++; if (cyc != 163) begin bad++; $display("FAIL equal_lock_cycle: got %0d want 163", cyc); end
        total++; if (ref_period !== 10'd20) begin bad++; $display("FAIL equal_ref_period: got %0d want 20", ref_period); end
        total++; if (fb_period !== 10'd20) begin bad++; $display("FAIL equal_fb_period: got %0d want 20", fb_period); end
        repeat (100) @(posedge clk);
        #1;
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL equal_hold_locked: got %b want 1", locked); end
        total++; if (lost_cnt != lost0) begin bad++; $display("FAIL equal_no_lost: got %0d pulses want 0", lost_cnt - lost0); end
    endtask

    task automatic test_off_freq();
        int cyc;
        bit saw_lock;
        do_reset();
        ref_per = 20; fb_per = 23;
        @(posedge clk); #1 fb_run = 1;
        repeat (5) @(posedge clk);
        #1 ref_run = 1;
        saw_lock = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (locked !== 1'b0) saw_lock = 1;
        end
        total++; if (saw_lock) begin bad++; $display("FAIL offfreq_no_lock: got locked=1 want 0"); end
        total++; if (ref_period !== 10'd20) begin bad++; $display("FAIL offfreq_ref_period: got %0d want 20", ref_period); end
        total++; if (fb_period !== 10'd23) begin bad++; $display("FAIL offfreq_fb_period: got %0d want 23", fb_period); end
        fb_per = 21;
        wait_lock(400, cyc);
        total++; if (cyc < 141 || cyc > 260) begin bad++; $display("FAIL offfreq_relock: got %0d want 141..260", cyc); end
        total++; if (fb_period !== 10'd21) begin bad++; $display("FAIL offfreq_fb21: got %0d want 21", fb_period); end
    endtask

    task automatic test_fb_stop();
        int cyc;
        int lost0;
        lost0 = lost_cnt;
        fb_run = 0;
        wait_unlock(1300, cyc);
        total++; if (cyc < 990 || cyc > 1080) begin bad++; $display("FAIL fbstop_unlock: got %0d want 990..1080", cyc); end
        total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL fbstop_pulse: got %b want 1", lock_lost); end
        @(posedge clk); #1;
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL fbstop_pulse_width: got %b want 0", lock_lost); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (lost_cnt - lost0 != 1) begin bad++; $display("FAIL fbstop_pulse_count: got %0d want 1", lost_cnt - lost0); end
        total++; if (lock_lost_sticky !== 1'b1) begin bad++; $display("FAIL fbstop_sticky: got %b want 1", lock_lost_sticky); end
        clr_sticky = 1'b1;
        @(posedge clk); #1 clr_sticky = 1'b0;
        total++; if (lock_lost_sticky !== 1'b0) begin bad++; $display("FAIL fbstop_clr: got %b want 0", lock_lost_sticky); end
    endtask

    task automatic test_ref_stop();
        int cyc;
        int lost0;
        do_reset();
        start_clocks(20);
        wait_lock(400, cyc);
        total++; if (cyc != 163) begin bad++; $display("FAIL refstop_first_lock: got %0d want 163", cyc); end
        lost0 = lost_cnt;
        ref_run = 0;
        wait_unlock(1300, cyc);
        total++; if (cyc < 990 || cyc > 1040) begin bad++; $display("FAIL refstop_unlock: got %0d want 990..1040", cyc); end
        total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL refstop_pulse: got %b want 1", lock_lost); end
        repeat (50) @(posedge clk);
        #1;
        total++; if (lost_cnt - lost0 != 1) begin bad++; $display("FAIL refstop_pulse_count: got %0d want 1", lost_cnt - lost0); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL refstop_locked: got %b want 0", locked); end
        total++; if (lock_lost_sticky !== 1'b1) begin bad++; $display("FAIL refstop_sticky: got %b want 1", lock_lost_sticky); end
        ref_run = 1;
        wait_lock(400, cyc);
        total++; if (cyc < 160 || cyc > 190) begin bad++; $display("FAIL refstop_relock: got %0d want 160..190", cyc); end
    endtask

    task automatic test_coincident();
        int cyc;
        do_reset();
        ref_per = 16; fb_per = 16;
        @(posedge clk); #1 ref_run = 1; fb_run = 1;
        wait_lock(400, cyc);
        total++; if (cyc != 131) begin bad++; $display("FAIL coinc_lock_cycle: got %0d want 131", cyc); end
        total++; if (fb_period !== 10'd16) begin bad++; $display("FAIL coinc_fb_period: got %0d want 16", fb_period); end
        clr_sticky = 1'b1;
        fb_run = 0;
        wait_unlock(1300, cyc);
        total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL coinc_pulse: got %b want 1", lock_lost); end
        total++; if (lock_lost_sticky !== 1'b1) begin bad++; $display("FAIL coinc_set_wins: got %b want 1", lock_lost_sticky); end
        @(posedge clk); #1;
        total++; if (lock_lost_sticky !== 1'b1) begin bad++; $display("FAIL coinc_set_wins_hold: got %b want 1", lock_lost_sticky); end
        @(posedge clk); #1;
        total++; if (lock_lost_sticky !== 1'b0) begin bad++; $display("FAIL coinc_later_clr: got %b want 0", lock_lost_sticky); end
        clr_sticky = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int lost0;
        do_reset();
        start_clocks(20);
        wait_lock(400, cyc);
        total++; if (cyc != 163) begin bad++; $display("FAIL midrst_first_lock: got %0d want 163", cyc); end
        repeat (7) @(posedge clk);
        #1;
        lost0 = lost_cnt;
        reset = 1'b1; ref_run = 0; fb_run = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_locked: got %b want 0", locked); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL midrst_lock_lost: got %b want 0", lock_lost); end
        total++; if (ref_period !== '0) begin bad++; $display("FAIL midrst_ref_period: got %0d want 0", ref_period); end
        total++; if (fb_period !== '0) begin bad++; $display("FAIL midrst_fb_period: got %0d want 0", fb_period); end
        start_clocks(20);
        wait_lock(400, cyc);
        total++; if (cyc != 163) begin bad++; $display("FAIL midrst_relock: got %0d want 163", cyc); end
        total++; if (lost_cnt != lost0) begin bad++; $display("FAIL midrst_no_lost: got %0d pulses want 0", lost_cnt - lost0); end
    endtask

    initial begin
        reset = 1'b1;
        clr_sticky = 1'b0;
        test_reset();
        test_lock_equal();
        test_off_freq();
        test_fb_stop();
        test_ref_stop();
        test_coincident();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
